// File: rtl/div32_seq_pkg.sv
// Shared constants, state encoding and the two's-complement helper for div32_seq.
package div32_seq_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH-1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction
endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle between the control unit and the sequential divider.
interface div32_seq_if;
  import div32_seq_pkg::*;

  logic             start;
  logic             Signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Div_Zero;
  logic             Div_Overflow;
  logic             Zero;

  modport master (
    output start, Signed, A, B,
    input  busy, done, Quotient, Remainder, Div_Zero, Div_Overflow, Zero
  );

  modport slave (
    input  start, Signed, A, B,
    output busy, done, Quotient, Remainder, Div_Zero, Div_Overflow, Zero
  );
endinterface

// File: rtl/div32_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div32_step
  import div32_seq_pkg::*;
(
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_t;

  assign w_sh = {i_r, i_q[WIDTH-1]};
  // R' < 2D, so the MSB of the (n+1)-bit difference is exactly the borrow.
  assign w_t  = w_sh - {1'b0, i_d};
  assign o_r  = w_t[WIDTH] ? w_sh[WIDTH-1:0] : w_t[WIDTH-1:0];
  assign o_q  = {i_q[WIDTH-2:0], ~w_t[WIDTH]};
endmodule

// File: rtl/div32_seq.sv
// Sequential signed/unsigned 32-bit divider, one restoring step per clock, registered outputs.
module div32_seq
  import div32_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  div32_seq_if.slave  bus
);
  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_d, r_q, r_r;
  logic             r_signed, r_neg_q, r_neg_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done, r_dz, r_ov, r_zero;
  logic [WIDTH-1:0] r_quot, r_rem;
  logic [WIDTH-1:0] w_r_nxt, w_q_nxt, w_quot, w_rem;

  div32_step u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  assign w_quot = r_neg_q ? neg2c(r_q) : r_q;
  assign w_rem  = r_neg_r ? neg2c(r_r) : r_r;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = PREP;
      PREP:    w_next = (r_b == '0) ? DONE : ITER;
      ITER:    if (r_cnt == '0) w_next = FIX;
      FIX:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_d <= '0; r_q <= '0; r_r <= '0;
      r_signed <= 1'b0; r_neg_q <= 1'b0; r_neg_r <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0; r_done <= 1'b0;
      r_dz   <= 1'b0; r_ov   <= 1'b0; r_zero <= 1'b0;
      r_quot <= '0;   r_rem  <= '0;
    end else begin
      // busy/done are decoded one cycle ahead so they are plain flops.
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      case (r_state)
        IDLE: if (bus.start) begin
          r_a      <= bus.A;
          r_b      <= bus.B;
          r_signed <= bus.Signed;
          r_dz     <= 1'b0;
          r_ov     <= 1'b0;
          r_zero   <= 1'b0;
        end
        PREP: begin
          r_q     <= (r_signed & r_a[WIDTH-1]) ? neg2c(r_a) : r_a;
          r_d     <= (r_signed & r_b[WIDTH-1]) ? neg2c(r_b) : r_b;
          r_neg_q <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r <= r_signed & r_a[WIDTH-1];
          r_r     <= '0;
          r_cnt   <= CNT_LAST;
          if (r_b == '0) begin
            r_quot <= ALL_ONES;
            r_rem  <= r_a;
            r_dz   <= 1'b1;
          end
        end
        ITER: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_quot <= w_quot;
          r_rem  <= w_rem;
          r_ov   <= r_signed & (r_a == INT_MIN) & (r_b == ALL_ONES);
          r_zero <= (w_quot == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.Quotient     = r_quot;
  assign bus.Remainder    = r_rem;
  assign bus.Div_Zero     = r_dz;
  assign bus.Div_Overflow = r_ov;
  assign bus.Zero         = r_zero;
endmodule

// File: tb/tb_div32_seq.sv
// Bench for div32_seq: directed corner cases plus a random sweep against an arithmetic reference.
module tb_div32_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  div32_seq_if bus ();

  div32_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output logic z);
    longint la, lb, lq, lr;
    dz = (b == 32'd0);
    ov = sg && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      la = sg ? longint'($signed(a)) : longint'({32'd0, a});
      lb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
    end
    z = (q == 32'd0);
  endtask

  // inj: re-assert start in cycles 5 and 35; rst_at: pulse rst in that cycle and abort.
  task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input bit inj, input int rst_at);
    logic [31:0] eq, er;
    logic        edz, eov, ez;
    int          lat;
    model(sg, a, b, eq, er, edz, eov, ez);
    @(negedge clk);
    bus.start = 1'b1; bus.Signed = sg; bus.A = a; bus.B = b;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus.start = inj && (c == 5 || c == 35);
      if (bus.start) begin
        bus.A = $urandom; bus.B = $urandom; bus.Signed = ~sg;
      end
      if (rst_at != 0 && c == rst_at) rst = 1'b1;
      if (rst_at != 0 && c == rst_at + 1) begin
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_quot", bus.Quotient, 32'd0);
        chk("rst_rem",  bus.Remainder, 32'd0);
        chk("rst_flags", {29'd0, bus.Div_Zero, bus.Div_Overflow, bus.Zero}, 32'd0);
        return;
      end
      if (c == 1) chk("busy_c1", {31'd0, bus.busy}, 32'd1);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, edz ? 32'd2 : 32'd35);
    chk("busy_done", {31'd0, bus.busy}, 32'd1);
    chk("quot", bus.Quotient, eq);
    chk("rem",  bus.Remainder, er);
    chk("div_zero", {31'd0, bus.Div_Zero}, {31'd0, edz});
    chk("div_ovf",  {31'd0, bus.Div_Overflow}, {31'd0, eov});
    chk("zero",     {31'd0, bus.Zero}, {31'd0, ez});
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse", {31'd0, bus.done}, 32'd0);
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
    chk("quot_hold", bus.Quotient, eq);
    chk("rem_hold",  bus.Remainder, er);
  endtask

  initial begin
    logic        sg;
    logic [31:0] a, b;
    int          sel;
    rst = 1'b1;
    bus.start = 1'b0; bus.Signed = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_quot", bus.Quotient, 32'd0);
    chk("reset_rem",  bus.Remainder, 32'd0);
    chk("reset_flags", {29'd0, bus.Div_Zero, bus.Div_Overflow, bus.Zero}, 32'd0);
    rst = 1'b0;

    run(1'b0, 32'd100, 32'd7, 1'b0, 0);
    run(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    run(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
    run(1'b0, 32'h1234_5678, 32'd0, 1'b0, 0);
    run(1'b1, 32'h1234_5678, 32'd0, 1'b0, 0);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run(1'b0, 32'd1000, 32'd9, 1'b1, 0);
    run(1'b1, 32'h0BAD_F00D, 32'd77, 1'b0, 10);
    run(1'b0, 32'd3, 32'd5, 1'b0, 0);
    run(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      sg  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      run(sg, a, b, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/div32_seq.md
# div32_seq

Sequential 32-bit integer divider for the lab ALU datapath. It performs the inverse of the adder/subtractor path: one restoring trial-subtract per clock, signed or unsigned, with start/busy/done handshaking. It produces quotient, remainder and status flags in the same style as the adder flags. It sits beside the combinational ALU and is selected by the control unit for DIV/REM operations.

## Interface
- n, 32, operand/result width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset; one clock; sampled on rising edge of clk
- start  in  1  request; accepted only when busy=0
- Signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- A  in  n  dividend; sampled with start
- B  in  n  divisor; sampled with start
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle pulse; results valid in that cycle and held until the next accepted start
- Quotient  out  n  result quotient
- Remainder  out  n  result remainder
- Div_Zero  out  1  B was zero
- Div_Overflow  out  1  signed 0x80000000 / 0xFFFFFFFF
- Zero  out  1  Quotient == 0

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE -> PREP: start=1 is sampled.
  - Latches A, B and Signed.
  - Clears done and the flags.
- PREP:
  - Takes magnitudes. If Signed and the sign bit is set, negate.
  - Records neg_q = Signed & (A[n-1] ^ B[n-1]) and neg_r = Signed & A[n-1].
  - Clears the remainder register and loads the iteration counter with n-1.
  - If B == 0: goes directly to DONE with Quotient=all ones, Remainder=A, Div_Zero=1.
  - Otherwise goes to ITER.
- ITER: one step per cycle.
  - R' = {R[n-1:0], Q[n-1]} as an (n+1)-bit value.
  - Trial T = R' - D at n+1 bits.
  - If T is non-negative: R=T and the shifted-in quotient bit is 1. Otherwise R=R' and the bit is 0.
  - Q shifts left each step.
  - The counter decrements. At 0, go to FIX.
- FIX:
  - Quotient = neg_q ? -Q : Q.
  - Remainder = neg_r ? -R : R.
  - Quotient truncates toward zero. Remainder takes the dividend's sign.
  - Div_Overflow = Signed & (A==0x80000000) & (B==0xFFFFFFFF). The algorithm already yields Q=0x80000000 and R=0 in that case, so no special path is needed.
  - Zero is computed from the final Quotient.
- DONE:
  - done=1 for exactly one cycle.
  - Next state is IDLE.
  - Outputs hold until the next accepted start.
- start while busy=1: ignored, no queuing.
- start in the DONE cycle: ignored. It is accepted from IDLE only.
- rst and start in the same cycle: rst wins.
- rst mid-operation: next state is IDLE, all outputs go to reset values, and the in-flight result is discarded.
- Reset values: busy=0, done=0, Quotient=0, Remainder=0, Div_Zero=0, Div_Overflow=0, Zero=0. Note that Zero resets to 0, unlike a combinational zero flag.

## Timing
- Call the cycle where start is sampled high in IDLE cycle 0.
- Normal path:
  - PREP in cycle 1.
  - ITER in cycles 2–33 (32 cycles).
  - FIX in cycle 34.
  - done high in cycle 35.
  - IDLE in cycle 36.
- Divide-by-zero path: PREP in cycle 1, done high in cycle 2.
- busy is high in cycles 1..35 (normal) or 1..2 (divide-by-zero).
- Back-to-back: the earliest next accepted start is cycle 36 (or 3 after divide-by-zero).
- All outputs are registered. Nothing combinational runs from inputs to outputs.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE/PREP/ITER/FIX/DONE)
  - WIDTH=32
  - the constants ALL_ONES and INT_MIN
- Sub-module div32_step: combinational single iteration.
  - Inputs: R, Q, D.
  - Outputs: next R, next Q.
  - Uses an (n+1)-bit subtract whose borrow selects restore.
- Negation is two's complement (~x + 1) and is shared between PREP and FIX.

## Test plan
- Unsigned 100/7, start at cycle 0 -> done in cycle 35; Quotient=14, Remainder=2, Zero=0, flags 0.
- Signed 0xFFFFFFF9 (-7) / 2 -> Quotient=0xFFFFFFFD (-3), Remainder=0xFFFFFFFF (-1); signed 7 / 0xFFFFFFFE (-2) -> Quotient=0xFFFFFFFD, Remainder=1.
- A=0x12345678, B=0, either sign mode -> done in cycle 2; Quotient=0xFFFFFFFF, Remainder=0x12345678, Div_Zero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> Quotient=0x80000000, Remainder=0, Div_Overflow=1; the same operands unsigned -> Quotient=0, Remainder=0x80000000, Zero=1, Div_Overflow=0.
- start re-asserted in cycles 5 and 35 -> ignored, result unchanged.
- rst in cycle 10 -> busy=0 and all outputs 0 in cycle 11; new start 3/5 unsigned -> Quotient=0, Remainder=3, Zero=1.
- Unsigned 0xFFFFFFFF / 1 -> Quotient=0xFFFFFFFF, Remainder=0. Random signed/unsigned sweep checked against a reference model.
